// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read/write port driver, 8-entry scoreboard with
// RAW/WAW interlock, same-cycle write-back bypass, and a one-entry output register.
module operand_fetch #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [AW-1:0]        in_src1,
    input  logic [AW-1:0]        in_src2,
    input  logic [AW-1:0]        in_dst,
    input  logic                 in_wb,

    output logic [AW-1:0]        read_add1,
    output logic [AW-1:0]        read_add2,
    input  logic [DW-1:0]        read_dat1,
    input  logic [DW-1:0]        read_dat2,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_op,
    output logic [AW-1:0]        out_dst,
    output logic                 out_wb,
    output logic [DW-1:0]        out_a,
    output logic [DW-1:0]        out_b,

    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_add,
    input  logic [DW-1:0]        wb_dat,

    output logic                 writ_ena,
    output logic [AW-1:0]        writ_add,
    output logic [DW-1:0]        writ_dat,

    output logic [(1<<AW)-1:0]   busy,
    output logic                 sb_err
);
    localparam int NREG = 1 << AW;

    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic            clr_src1;
    logic            clr_src2;
    logic            clr_dst;
    logic            hazard;
    logic            issue;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;

    assign read_add1 = in_src1;
    assign read_add2 = in_src2;

    assign writ_ena = rst_n && wb_valid;
    assign writ_add = wb_add;
    assign writ_dat = wb_dat;

    always_comb begin
        clr_vec = '0;
        if (wb_valid) begin
            clr_vec[wb_add] = 1'b1;
        end
    end

    assign clr_src1 = clr_vec[in_src1];
    assign clr_src2 = clr_vec[in_src2];
    assign clr_dst  = clr_vec[in_dst];

    // A register whose producer is writing back this cycle is not a hazard.
    assign hazard = (busy[in_src1] && !clr_src1) ||
                    (busy[in_src2] && !clr_src2) ||
                    (in_wb && busy[in_dst] && !clr_dst);

    // Both sides use valid/ready: a transfer happens on a rising edge where
    // valid && ready; valid never waits on ready, and a held output is stable.
    assign in_ready = rst_n && (!out_valid || out_ready) && !hazard;
    assign issue    = in_valid && in_ready;

    assign op_a = clr_src1 ? wb_dat : read_dat1;
    assign op_b = clr_src2 ? wb_dat : read_dat2;

    always_comb begin
        set_vec = '0;
        if (issue && in_wb) begin
            set_vec[in_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_dst   <= '0;
            out_wb    <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            busy      <= '0;
            sb_err    <= 1'b0;
        end else begin
            if (issue) begin
                out_valid <= 1'b1;
                out_op    <= in_op;
                out_dst   <= in_dst;
                out_wb    <= in_wb;
                out_a     <= op_a;
                out_b     <= op_b;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Set after clear so a new issue keeps a register busy.
            busy <= (busy & ~clr_vec) | set_vec;
            if (wb_valid && !busy[wb_add]) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic checked
// against a pending-set / expected-queue reference model.
module tb_operand_fetch;
    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 8;
    localparam int TW   = 4 + AW + 1 + 2 * DW;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [AW-1:0]   in_src1;
    logic [AW-1:0]   in_src2;
    logic [AW-1:0]   in_dst;
    logic            in_wb;
    logic [AW-1:0]   read_add1;
    logic [AW-1:0]   read_add2;
    logic [DW-1:0]   read_dat1;
    logic [DW-1:0]   read_dat2;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_op;
    logic [AW-1:0]   out_dst;
    logic            out_wb;
    logic [DW-1:0]   out_a;
    logic [DW-1:0]   out_b;
    logic            wb_valid;
    logic [AW-1:0]   wb_add;
    logic [DW-1:0]   wb_dat;
    logic            writ_ena;
    logic [AW-1:0]   writ_add;
    logic [DW-1:0]   writ_dat;
    logic [NREG-1:0] busy;
    logic            sb_err;

    // regfile model, fed only by the DUT write port and a bench preload port
    logic            pre_en;
    logic [AW-1:0]   pre_add;
    logic [DW-1:0]   pre_dat;
    logic [DW-1:0]   rf [NREG];

    // reference model state
    logic [DW-1:0]   mrf [NREG];
    bit              pend [NREG];
    logic [TW-1:0]   exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    operand_fetch #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_wb(in_wb),
        .read_add1(read_add1), .read_add2(read_add2),
        .read_dat1(read_dat1), .read_dat2(read_dat2),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_dst(out_dst), .out_wb(out_wb), .out_a(out_a), .out_b(out_b),
        .wb_valid(wb_valid), .wb_add(wb_add), .wb_dat(wb_dat),
        .writ_ena(writ_ena), .writ_add(writ_add), .writ_dat(writ_dat),
        .busy(busy), .sb_err(sb_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) rf[pre_add] <= pre_dat;
        else if (writ_ena) rf[writ_add] <= writ_dat;
    end
    assign read_dat1 = rf[read_add1];
    assign read_dat2 = rf[read_add2];

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int r, input logic [DW-1:0] v);
        pre_en  = 1'b1;
        pre_add = AW'(r);
        pre_dat = v;
        mrf[r]  = v;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic drive_instr(input logic [3:0] op, input int s1, input int s2,
                               input int d, input logic wb);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = AW'(s1);
        in_src2  = AW'(s2);
        in_dst   = AW'(d);
        in_wb    = wb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_instr(4'd1, 0, 0, 0, 1'b1);
        wb_valid = 1'b1; wb_add = 3'd2; wb_dat = 16'h5555;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (busy !== 8'h00) begin n_errors++; $display("FAIL reset_busy: got %h exp 00", busy); end
        n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL reset_sb_err: got %b exp 0", sb_err); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        n_checks++; if (writ_ena !== 1'b0) begin n_errors++; $display("FAIL reset_writ_ena: got %b exp 0", writ_ena); end
        n_checks++; if ({out_op, out_dst, out_wb, out_a, out_b} !== '0) begin n_errors++; $display("FAIL reset_out_fields: got %h exp 0", {out_op, out_dst, out_wb, out_a, out_b}); end
        in_valid = 1'b0;
        wb_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_instr(4'd2, 3, 5, 1, 1'b1);
        out_ready = 1'b1;
        #2;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready: got %b exp 1", in_ready); end
        n_checks++; if (read_add1 !== 3'd3 || read_add2 !== 3'd5) begin n_errors++; $display("FAIL basic_read_add: got %0d/%0d exp 3/5", read_add1, read_add2); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %b exp 1", out_valid); end
        n_checks++; if (out_a !== 16'h1234 || out_b !== 16'h00FF) begin n_errors++; $display("FAIL basic_operands: got %h/%h exp 1234/00ff", out_a, out_b); end
        n_checks++; if (out_op !== 4'd2 || out_dst !== 3'd1 || out_wb !== 1'b1) begin n_errors++; $display("FAIL basic_fields: got %h/%h/%b exp 2/1/1", out_op, out_dst, out_wb); end
        n_checks++; if (busy !== 8'h02) begin n_errors++; $display("FAIL basic_busy: got %h exp 02", busy); end
    endtask

    task automatic test_raw();
        drive_instr(4'd3, 1, 3, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL raw_stall[%0d]: got in_ready %b exp 0", i, in_ready); end
            tick();
        end
        wb_valid = 1'b1; wb_add = 3'd1; wb_dat = 16'hBEEF;
        #2;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL raw_bypass_ready: got %b exp 1", in_ready); end
        n_checks++; if (writ_ena !== 1'b1 || writ_add !== 3'd1 || writ_dat !== 16'hBEEF) begin n_errors++; $display("FAIL raw_write_port: got %b/%0d/%h exp 1/1/beef", writ_ena, writ_add, writ_dat); end
        tick();
        mrf[1] = 16'hBEEF;
        in_valid = 1'b0; wb_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_a !== 16'hBEEF || out_b !== 16'h1234) begin n_errors++; $display("FAIL raw_bypass_data: got %b/%h/%h exp 1/beef/1234", out_valid, out_a, out_b); end
        n_checks++; if (busy !== 8'h00) begin n_errors++; $display("FAIL raw_busy_clear: got %h exp 00", busy); end
        tick();
    endtask

    task automatic test_waw();
        drive_instr(4'd4, 0, 0, 4, 1'b1);
        tick();
        n_checks++; if (busy !== 8'h10) begin n_errors++; $display("FAIL waw_first_busy: got %h exp 10", busy); end
        for (int i = 0; i < 2; i++) begin
            #2;
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL waw_stall[%0d]: got in_ready %b exp 0", i, in_ready); end
            tick();
        end
        wb_valid = 1'b1; wb_add = 3'd4; wb_dat = 16'h4444;
        #2;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL waw_release_ready: got %b exp 1", in_ready); end
        tick();
        mrf[4] = 16'h4444;
        in_valid = 1'b0;
        n_checks++; if (busy !== 8'h10) begin n_errors++; $display("FAIL waw_set_wins: got %h exp 10", busy); end
        wb_dat = 16'h4445;
        tick();
        mrf[4] = 16'h4445;
        wb_valid = 1'b0;
        n_checks++; if (busy !== 8'h00 || sb_err !== 1'b0) begin n_errors++; $display("FAIL waw_final: got busy %h sb_err %b exp 00/0", busy, sb_err); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive_instr(4'd5, 3, 5, 0, 1'b0);
        tick();
        out_ready = 1'b0;
        drive_instr(4'd6, 5, 3, 7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out_op !== 4'd5 || out_a !== 16'h1234 || out_b !== 16'h00FF) begin n_errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%h/%h exp 1/5/1234/00ff", i, out_valid, out_op, out_a, out_b); end
            tick();
        end
        out_ready = 1'b1;
        #2;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_op !== 4'd6 || out_a !== 16'h00FF || out_b !== 16'h1234 || out_dst !== 3'd7 || out_wb !== 1'b1) begin n_errors++; $display("FAIL bp_next: got %h/%h/%h/%0d/%b exp 6/00ff/1234/7/1", out_op, out_a, out_b, out_dst, out_wb); end
        n_checks++; if (busy !== 8'h80) begin n_errors++; $display("FAIL bp_busy: got %h exp 80", busy); end
        wb_valid = 1'b1; wb_add = 3'd7; wb_dat = 16'h7777;
        tick();
        mrf[7] = 16'h7777;
        wb_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int cand [$];
        bit clr [NREG];
        bit blocked, exp_ready, exp_issue;
        logic [DW-1:0] ea, eb;
        for (int r = 0; r < NREG; r++) pend[r] = 1'b0;
        exp_q.delete();
        for (int r = 0; r < NREG; r++) preload(r, DW'($urandom));
        n_checks++; if (busy !== 8'h00 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rand_start: got busy %h out_valid %b exp 00/0", busy, out_valid); end
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive_instr(4'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cand.delete();
            for (int r = 0; r < NREG; r++) if (pend[r]) cand.push_back(r);
            wb_valid = 1'b0;
            wb_add   = AW'($urandom_range(0, 7));
            wb_dat   = DW'($urandom);
            if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
                wb_valid = 1'b1;
                wb_add   = AW'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            #2;
            for (int r = 0; r < NREG; r++) clr[r] = wb_valid && (int'(wb_add) == r);
            blocked = (pend[in_src1] && !clr[in_src1]) || (pend[in_src2] && !clr[in_src2]) ||
                      (in_wb && pend[in_dst] && !clr[in_dst]);
            exp_ready = !(exp_q.size() != 0 && !out_ready) && !blocked;
            exp_issue = in_valid && exp_ready;
            n_checks++; if (in_ready !== exp_ready) begin n_errors++; $display("FAIL rand_in_ready[%0d]: got %b exp %b", cyc, in_ready, exp_ready); end
            n_checks++; if (out_valid !== (exp_q.size() != 0)) begin n_errors++; $display("FAIL rand_out_valid[%0d]: got %b exp %b", cyc, out_valid, exp_q.size() != 0); end
            n_checks++; if (writ_ena !== wb_valid || (wb_valid && (writ_add !== wb_add || writ_dat !== wb_dat))) begin n_errors++; $display("FAIL rand_write_port[%0d]: got %b/%0d/%h exp %b/%0d/%h", cyc, writ_ena, writ_add, writ_dat, wb_valid, wb_add, wb_dat); end
            if (exp_q.size() != 0 && out_ready) begin
                n_checks++; if ({out_op, out_dst, out_wb, out_a, out_b} !== exp_q[0]) begin n_errors++; $display("FAIL rand_out_data[%0d]: got %h exp %h", cyc, {out_op, out_dst, out_wb, out_a, out_b}, exp_q[0]); end
            end
            ea = clr[in_src1] ? wb_dat : mrf[in_src1];
            eb = clr[in_src2] ? wb_dat : mrf[in_src2];
            @(posedge clk);
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (exp_issue) exp_q.push_back({in_op, in_dst, in_wb, ea, eb});
            if (wb_valid) begin
                mrf[wb_add]  = wb_dat;
                pend[wb_add] = 1'b0;
            end
            if (exp_issue && in_wb) pend[in_dst] = 1'b1;
            #1;
            for (int r = 0; r < NREG; r++) begin
                if (busy[r] !== pend[r]) begin
                    n_checks++; n_errors++;
                    $display("FAIL rand_busy[%0d] reg %0d: got %b exp %b", cyc, r, busy[r], pend[r]);
                end
            end
            n_checks++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (pend[r]) begin
                wb_valid = 1'b1; wb_add = AW'(r); wb_dat = 16'h0000;
                tick();
                mrf[r] = 16'h0000; pend[r] = 1'b0;
            end
        end
        wb_valid = 1'b0;
        tick();
        n_checks++; if (busy !== 8'h00 || out_valid !== 1'b0 || sb_err !== 1'b0) begin n_errors++; $display("FAIL rand_drain: got busy %h out_valid %b sb_err %b exp 00/0/0", busy, out_valid, sb_err); end
    endtask

    task automatic test_sb_err();
        wb_valid = 1'b1; wb_add = 3'd6; wb_dat = 16'h6666;
        #2;
        n_checks++; if (writ_ena !== 1'b1 || writ_add !== 3'd6 || sb_err !== 1'b0) begin n_errors++; $display("FAIL sberr_write: got %b/%0d/%b exp 1/6/0", writ_ena, writ_add, sb_err); end
        tick();
        mrf[6] = 16'h6666;
        wb_valid = 1'b0;
        n_checks++; if (sb_err !== 1'b1 || busy !== 8'h00) begin n_errors++; $display("FAIL sberr_set: got sb_err %b busy %h exp 1/00", sb_err, busy); end
        repeat (3) tick();
        n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL sberr_sticky: got %b exp 1", sb_err); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive_instr(4'd7, 0, 0, 1, 1'b1);
        tick();
        drive_instr(4'd8, 0, 0, 4, 1'b1);
        tick();
        n_checks++; if (busy !== 8'h12 || out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_setup: got busy %h out_valid %b exp 12/1", busy, out_valid); end
        out_ready = 1'b0;
        drive_instr(4'd9, 1, 0, 2, 1'b0);
        wb_valid = 1'b1; wb_add = 3'd2; wb_dat = 16'h2222;
        #2;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_stall: got %b exp 0", in_ready); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 8'h00 || in_ready !== 1'b0 || writ_ena !== 1'b0) begin n_errors++; $display("FAIL rmid_async: got %b/%h/%b/%b exp 0/00/0/0", out_valid, busy, in_ready, writ_ena); end
        n_checks++; if (sb_err !== 1'b0 || out_a !== 16'h0000) begin n_errors++; $display("FAIL rmid_clear: got sb_err %b out_a %h exp 0/0000", sb_err, out_a); end
        in_valid = 1'b0; wb_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        wb_valid = 1'b1; wb_add = 3'd1; wb_dat = 16'h1111;
        tick();
        wb_valid = 1'b0;
        n_checks++; if (sb_err !== 1'b1 || busy !== 8'h00) begin n_errors++; $display("FAIL rmid_late_wb: got sb_err %b busy %h exp 1/00", sb_err, busy); end
    endtask

    initial begin
        in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0; in_dst = '0; in_wb = 1'b0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_add = '0; wb_dat = '0;
        pre_en = 1'b0; pre_add = '0; pre_dat = '0;
        test_reset();
        for (int r = 0; r < NREG; r++) preload(r, 16'h0000);
        preload(3, 16'h1234);
        preload(5, 16'h00FF);
        test_basic();
        test_raw();
        test_waw();
        test_backpressure();
        test_random();
        test_sb_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
